// File: rtl/isqrt_seq.sv
// isqrt_seq: sequential integer square root (digit-by-digit, restoring).
// Resolves one root bit per clock and returns floor(sqrt(x)) together with
// the remainder x - root^2.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand present on in_data
//   in_ready   unit is idle and can accept an operand
//   in_data    unsigned operand x (WIDTH bits)
//   out_valid  result present on root/rem
//   out_ready  consumer takes the result
//   root       floor(sqrt(x)) (HALF bits)
//   rem        x - root^2 (HALF+1 bits)
module isqrt_seq #(
  parameter  int WIDTH = 6,
  localparam int HALF  = WIDTH / 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [HALF-1:0] root,
  output logic [HALF:0]   rem
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] op_q;
  logic [HALF-1:0]  root_part;
  logic [HALF+1:0]  rem_part;
  logic [CW-1:0]    cnt;

  logic [HALF+1:0]  trial;
  logic [HALF+1:0]  test;
  logic             take;
  logic [HALF+1:0]  rem_nxt;
  logic [HALF-1:0]  root_nxt;
  logic             accept;
  logic             last_iter;

  // One restoring step. The partial remainder never exceeds twice the
  // partial root, so shifting it left by 2 inside HALF+2 bits is lossless.
  always_comb begin
    trial    = (rem_part << 2) | {{HALF{1'b0}}, op_q[WIDTH-1 -: 2]};
    test     = {root_part, 2'b01};
    take     = (trial >= test);
    rem_nxt  = take ? (trial - test) : trial;
    root_nxt = (root_part << 1) | HALF'(take);
  end

  assign accept    = (state == IDLE) && in_valid;
  assign last_iter = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath. root/rem are separate output registers so the last result
  // stays visible while the next operand is being worked on.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      root_part <= '0;
      rem_part  <= '0;
      cnt       <= '0;
      root      <= '0;
      rem       <= '0;
    end else if (accept) begin
      op_q      <= in_data;
      root_part <= '0;
      rem_part  <= '0;
      cnt       <= CW'(HALF - 1);
    end else if (state == BUSY) begin
      op_q      <= op_q << 2;
      root_part <= root_nxt;
      rem_part  <= rem_nxt;
      if (last_iter) begin
        root <= root_nxt;
        rem  <= rem_nxt[HALF:0];
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_isqrt_seq.sv
// Directed bench for isqrt_seq: default WIDTH=6 instance plus WIDTH=8 and
// WIDTH=2 instances for the parameter sweep.
module tb_isqrt_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=6
  logic       in_valid = 1'b0, out_ready = 1'b1;
  logic [5:0] in_data = '0;
  logic       in_ready, out_valid;
  logic [2:0] root;
  logic [3:0] rem;

  // WIDTH=8
  logic       in_valid8 = 1'b0, out_ready8 = 1'b1;
  logic [7:0] in_data8 = '0;
  logic       in_ready8, out_valid8;
  logic [3:0] root8;
  logic [4:0] rem8;

  // WIDTH=2
  logic       in_valid2 = 1'b0, out_ready2 = 1'b1;
  logic [1:0] in_data2 = '0;
  logic       in_ready2, out_valid2;
  logic [0:0] root2;
  logic [1:0] rem2;

  int n_checks = 0;
  int n_fail   = 0;

  isqrt_seq #(.WIDTH(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .root(root), .rem(rem)
  );

  isqrt_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .out_valid(out_valid8), .out_ready(out_ready8),
    .root(root8), .rem(rem8)
  );

  isqrt_seq #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .root(root2), .rem(rem2)
  );

  // Advance past the next rising edge; inputs are driven and outputs
  // sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_root(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || root !== 3'd0 || rem !== 4'd0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b root=%0d rem=%0d, want 1 0 0 0",
               in_ready, out_valid, root, rem);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_data   = 6'd36;
    in_valid  = 1'b1;
    tick();                       // accepting edge N
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL single_in_ready cyc%0d: got %b want 0", i, in_ready);
      end
      n_checks++;
      if (out_valid !== (i == 3 ? 1'b0 : 1'b0) && i < 3) begin
        n_fail++;
        $display("FAIL single_early_valid cyc%0d: got %b want 0", i, out_valid);
      end
      if (i < 3) tick();
    end
    tick();                       // edge N+3
    n_checks++;
    if (out_valid !== 1'b1 || root !== 3'd6 || rem !== 4'd0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_result: valid=%b root=%0d rem=%0d in_ready=%b, want 1 6 0 0",
               out_valid, root, rem, in_ready);
    end
    tick();                       // edge N+4 handoff
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_idle: valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_exhaustive();
    out_ready = 1'b1;
    for (int x = 0; x < 64; x++) begin
      int k = 0;
      int er;
      er = ref_root(x);
      in_data  = 6'(x);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      while (out_valid !== 1'b1 && k < 20) begin
        tick();
        k++;
      end
      n_checks++;
      if (out_valid !== 1'b1 || k != 3) begin
        n_fail++;
        $display("FAIL exh_latency x=%0d: valid=%b cycles=%0d, want 1 3", x, out_valid, k);
      end
      n_checks++;
      if (root !== 3'(er) || rem !== 4'(x - er * er)) begin
        n_fail++;
        $display("FAIL exh_value x=%0d: root=%0d rem=%0d, want %0d %0d",
                 x, root, rem, er, x - er * er);
      end
      n_checks++;
      if (int'(root) * int'(root) + int'(rem) != x || int'(rem) > 2 * int'(root)) begin
        n_fail++;
        $display("FAIL exh_roundtrip x=%0d: root=%0d rem=%0d", x, root, rem);
      end
      tick();                     // handoff, back to IDLE
    end
  endtask

  task automatic test_boundaries();
    int xs [4] = '{63, 48, 1, 0};
    int rs [4] = '{7, 6, 1, 0};
    int ms [4] = '{14, 12, 0, 0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data  = 6'(xs[i]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      n_checks++;
      if (out_valid !== 1'b1 || root !== 3'(rs[i]) || rem !== 4'(ms[i])) begin
        n_fail++;
        $display("FAIL boundary x=%0d: valid=%b root=%0d rem=%0d, want 1 %0d %0d",
                 xs[i], out_valid, root, rem, rs[i], ms[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_data   = 6'd50;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || root !== 3'd7 || rem !== 4'd1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure cyc%0d: valid=%b root=%0d rem=%0d in_ready=%b, want 1 7 1 0",
                 i, out_valid, root, rem, in_ready);
      end
      in_valid = 1'b1;            // must be ignored while holding DONE
      in_data  = 6'(i);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 1'b1 || root !== 3'd7 || rem !== 4'd1) begin
      n_fail++;
      $display("FAIL backpressure_final: valid=%b root=%0d rem=%0d, want 1 7 1",
               out_valid, root, rem);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || root !== 3'd7 || rem !== 4'd1) begin
      n_fail++;
      $display("FAIL backpressure_handoff: valid=%b in_ready=%b root=%0d rem=%0d, want 0 1 7 1",
               out_valid, in_ready, root, rem);
    end
  endtask

  task automatic test_input_noise();
    out_ready = 1'b0;
    in_data   = 6'd15;
    in_valid  = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 6'($urandom_range(0, 63));
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b1 || root !== 3'd3 || rem !== 4'd6) begin
      n_fail++;
      $display("FAIL noise_result: valid=%b root=%0d rem=%0d, want 1 3 6", out_valid, root, rem);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 6'd0;
    tick();                       // handoff edge: operand must not be taken
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL noise_handoff: in_ready=%b valid=%b, want 1 0", in_ready, out_valid);
    end
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL noise_no_accept: in_ready=%b valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_data   = 6'd63;
    in_valid  = 1'b1;
    tick();                       // accept
    in_valid = 1'b0;
    tick();                       // first BUSY edge
    rst = 1'b1;
    tick();                       // second BUSY edge, reset applied
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || root !== 3'd0 || rem !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid: in_ready=%b valid=%b root=%0d rem=%0d, want 1 0 0 0",
               in_ready, out_valid, root, rem);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_stale cyc%0d: valid=%b in_ready=%b, want 0 1", i, out_valid, in_ready);
      end
    end
    in_data  = 6'd4;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (out_valid !== 1'b1 || root !== 3'd2 || rem !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_after_op: valid=%b root=%0d rem=%0d, want 1 2 0", out_valid, root, rem);
    end
    tick();
  endtask

  task automatic test_width8();
    int xs [4] = '{255, 0, 16, 200};
    int rs [4] = '{15, 0, 4, 14};
    int ms [4] = '{30, 0, 0, 4};
    out_ready8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int k = 0;
      in_data8  = 8'(xs[i]);
      in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      while (out_valid8 !== 1'b1 && k < 20) begin
        tick();
        k++;
      end
      n_checks++;
      if (out_valid8 !== 1'b1 || k != 4 || root8 !== 4'(rs[i]) || rem8 !== 5'(ms[i])) begin
        n_fail++;
        $display("FAIL w8 x=%0d: valid=%b cycles=%0d root=%0d rem=%0d, want 1 4 %0d %0d",
                 xs[i], out_valid8, k, root8, rem8, rs[i], ms[i]);
      end
      tick();
    end
  endtask

  task automatic test_width2();
    int rs [4] = '{0, 1, 1, 1};
    int ms [4] = '{0, 0, 1, 2};
    out_ready2 = 1'b1;
    for (int x = 0; x < 4; x++) begin
      int k = 0;
      in_data2  = 2'(x);
      in_valid2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      while (out_valid2 !== 1'b1 && k < 20) begin
        tick();
        k++;
      end
      n_checks++;
      if (out_valid2 !== 1'b1 || k != 1 || root2 !== 1'(rs[x]) || rem2 !== 2'(ms[x])) begin
        n_fail++;
        $display("FAIL w2 x=%0d: valid=%b cycles=%0d root=%0d rem=%0d, want 1 1 %0d %0d",
                 x, out_valid2, k, root2, rem2, rs[x], ms[x]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_exhaustive();
    test_boundaries();
    test_backpressure();
    test_input_noise();
    test_reset_mid();
    test_width8();
    test_width2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/isqrt_seq.md
# isqrt_seq

Sequential integer square-root unit: the inverse of the squaring datapath. It accepts an unsigned WIDTH-bit operand and returns floor(sqrt(x)) plus the remainder x − root². It uses a digit-by-digit (restoring) algorithm that resolves one root bit per clock, behind valid/ready handshakes on both sides. It sits downstream of the squarer in the arithmetic library and serves as its round-trip checker and as a standalone root extractor.

## Interface
- WIDTH, 6: operand width in bits. Must be even and ≥ 2.
- HALF, WIDTH/2 (derived localparam, not overridable): root width and iteration count.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- in_valid  input  1  operand present on in_data.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  unsigned operand x.
- out_valid  output  1  result present on root/rem.
- out_ready  input  1  consumer takes result.
- root  output  HALF  floor(sqrt(x)).
- rem  output  HALF+1  x − root², range 0..2·root.

## Operation
- FSM states: IDLE, BUSY, DONE. Encoding is free.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: latch in_data into the operand shift register; clear the partial root and partial remainder; load iteration counter with HALF−1; go BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each cycle: trial = (rem_part<<2) | top two operand bits; test = (root_part<<2) | 1.
  - If trial ≥ test: rem_part = trial − test, root_part = (root_part<<1)|1.
  - Else: rem_part = trial, root_part = root_part<<1.
  - Shift the operand left by 2.
  - When the counter is 0, go DONE; otherwise decrement.
- DONE:
  - out_valid=1; root and rem hold final values, stable until handshake.
  - On out_ready: go IDLE.
  - in_ready=0 in DONE; no operand is accepted in the same cycle as result handoff.
- Width rules:
  - Internal partial-remainder register is HALF+2 bits, so trial never overflows.
  - Final remainder always fits in HALF+1 bits.
  - No truncation warnings are permitted.
- in_data is sampled only at the accepting edge. Later changes have no effect.
- out_ready while not in DONE is ignored. in_valid outside IDLE is ignored (not queued).

## Timing
- Reset (rst=1 at an edge):
  - State=IDLE, in_ready=1, out_valid=0, root=0, rem=0, all internal registers 0.
  - Reset overrides any state, including mid-BUSY or DONE with out_valid high. The in-flight result is discarded, no output is produced for it.
- Latency:
  - Operand accepted at edge N → out_valid high after edge N+HALF (3 cycles at default).
  - With out_ready=1, DONE lasts exactly one cycle. in_ready returns after edge N+HALF+1.
  - Next accept possible at edge N+HALF+2. Throughput: one result per HALF+2 cycles.
- Backpressure: out_ready=0 holds DONE indefinitely, with root/rem/out_valid unchanged.
- Outputs root/rem are registered. Between operations they hold the last result; only out_valid qualifies them.
- Boundaries:
  - x=0 → root 0, rem 0.
  - x=2^WIDTH−1 → root 2^HALF−1, rem 2·(2^HALF−1).
  - Perfect squares → rem 0.

## Test plan
- Reset then single op: rst 1 cycle, in_data=36, in_valid 1 cycle, out_ready=1 → out_valid after exactly 3 edges, root=6, rem=0. in_ready low for 4 cycles total.
- Exhaustive WIDTH=6: all x in 0..63 back-to-back, out_ready=1 → root=floor(sqrt(x)), rem=x−root², checked against the squarer model (root² + rem == x). Includes 63→7/14, 48→6/12, 1→1/0, 0→0/0.
- Backpressure: x=50, out_ready=0 for 10 cycles after out_valid → root=7, rem=1 held stable; in_ready=0 throughout. Handoff on first out_ready=1, then IDLE.
- Input noise: accept x=15, then toggle in_data/in_valid during BUSY and DONE → single result root=3, rem=6. No second operand accepted until IDLE.
- Reset mid-operation: accept x=63, assert rst at the 2nd BUSY edge → next cycle in_ready=1, out_valid=0, root=0, rem=0. No stale out_valid appears. A subsequent x=4 yields 2/0.
- Parameter sweep: WIDTH=8 and WIDTH=2 → x=255 gives 15/30 in 4 cycles; for WIDTH=2, x=3 gives 1/2 in 1 cycle.
